// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory fetch bus between IF stage and imem
interface if_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    // Fetch stage drives the address and consumes the same-cycle instruction word
    modport master (
        output imem_addr,
        input  imem_rdata
    );

    // Instruction memory answers combinationally
    modport slave (
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with BHT/BTB branch prediction
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [31:0]       redirect_pc,
    input  logic              upd_en,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    if_stage_if.master        imem,
    output logic [31:0]       instr_IF,
    output logic [31:0]       pc_IF,
    output logic [31:0]       pcnext_IF,
    output logic              prediction_IF
);

    localparam int ENTRIES = 16;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    logic [1:0]  bht        [ENTRIES];
    logic        btb_valid  [ENTRIES];
    logic [25:0] btb_tag    [ENTRIES];
    logic [31:0] btb_target [ENTRIES];

    logic [3:0]  lookup_idx;
    logic        btb_hit;
    logic        pred_taken;
    logic [3:0]  upd_idx;

    // Word-alignment bits of the update address carry no predictor information
    logic        unused_upd_bits;
    assign unused_upd_bits = ^upd_pc[1:0];

    assign imem.imem_addr = pc;
    assign pc_plus4       = pc + 32'd4;
    assign lookup_idx     = pc[5:2];
    assign upd_idx        = upd_pc[5:2];

    // Prediction reads the tables as they stand before this edge's update
    always_comb begin
        btb_hit    = btb_valid[lookup_idx] && (btb_tag[lookup_idx] == pc[31:6]);
        pred_taken = btb_hit && bht[lookup_idx][1];
    end

    // Next-PC priority: correction beats stall, stall beats prediction
    always_comb begin
        next_pc = pc_plus4;
        if (redirect_en) begin
            next_pc = redirect_pc;
        end else if (stall) begin
            next_pc = pc;
        end else if (pred_taken) begin
            next_pc = btb_target[lookup_idx];
        end
    end

    // PC register and IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            instr_IF      <= NOP_INSTR;
            pc_IF         <= 32'd0;
            pcnext_IF     <= 32'd0;
            prediction_IF <= 1'b0;
        end else begin
            pc <= next_pc;
            if (redirect_en) begin
                instr_IF      <= NOP_INSTR;
                pc_IF         <= 32'd0;
                pcnext_IF     <= 32'd0;
                prediction_IF <= 1'b0;
            end else if (!stall) begin
                instr_IF      <= imem.imem_rdata;
                pc_IF         <= pc;
                pcnext_IF     <= pc_plus4;
                prediction_IF <= pred_taken;
            end
        end
    end

    // Predictor training from resolved branches, independent of pipeline flow control
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i]        <= 2'b01;
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= 26'd0;
                btb_target[i] <= 32'd0;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                if (bht[upd_idx] != 2'b11) begin
                    bht[upd_idx] <= bht[upd_idx] + 2'b01;
                end
                btb_valid[upd_idx]  <= 1'b1;
                btb_tag[upd_idx]    <= upd_pc[31:6];
                btb_target[upd_idx] <= upd_target;
            end else if (bht[upd_idx] != 2'b00) begin
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
            end
        end
    end

endmodule
